cfglut_loader: RTL and testbench

Serial configuration loader that writes 32-bit truth tables into a chain of NUM_LUTS dynamically reconfigurable 5-input LUTs (CFGLUT5-style: CDI/CE/CDO shift interface). It sits directly upstream of the LUT chain and drives its CDI and CE pins. It accepts words over a valid/ready handshake and shifts each one in MSB first over 32 clocks. It also captures the displaced contents from the chain's CDO as readback words.

---
 rtl/cfglut_loader.sv | 121 ++++++++++++
 tb/tb_cfglut_loader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cfglut_loader.sv
// cfglut_loader
//   Serial configuration loader for a chain of CFGLUT5-style reconfigurable
//   LUTs. Accepts 32-bit truth tables over a valid/ready handshake and shifts
//   each one MSB first into the chain over 32 clocks. It simultaneously
//   captures the bits displaced from the end of the chain as readback words.
//
// Ports
//   CLK       clock, rising edge
//   RST       asynchronous active-high reset
//   WR_VALID  WR_DATA holds a word to load
//   WR_READY  word accepted this cycle when WR_VALID is also high
//   WR_DATA   truth table, bit 31 shifted first
//   CFG_CE    shift enable to every LUT in the chain
//   CFG_CDI   serial data into the first LUT
//   CFG_CDO   serial data out of the last LUT
//   RB_VALID  one-cycle pulse, RB_DATA holds a fresh readback word
//   RB_DATA   word shifted out of the last LUT, first-out bit in bit 31
//   BUSY      shift in progress (same as CFG_CE)
//   DONE      one-cycle pulse after every NUM_LUTS-th completed word
module cfglut_loader #(
  parameter int NUM_LUTS = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        WR_VALID,
  output logic        WR_READY,
  input  logic [31:0] WR_DATA,
  output logic        CFG_CE,
  output logic        CFG_CDI,
  input  logic        CFG_CDO,
  output logic        RB_VALID,
  output logic [31:0] RB_DATA,
  output logic        BUSY,
  output logic        DONE
);

  localparam int WCW = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1;
  localparam logic [WCW-1:0] WORD_LAST = WCW'(NUM_LUTS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic           accept;
  logic           last_bit;
  logic [31:0]    shreg;
  logic [31:0]    rb_shift;
  logic [4:0]     bit_cnt;
  logic [WCW-1:0] word_cnt;

  // The 32nd shift cycle is the only point inside SHIFT where a new word
  // may be taken, which gives gapless back-to-back loading.
  assign last_bit = (state == SHIFT) && (bit_cnt == 5'd31);

  always_comb begin
    state_nxt = state;
    WR_READY  = 1'b0;
    accept    = 1'b0;
    WR_READY  = !RST && ((state == IDLE) || last_bit);
    accept    = WR_VALID && WR_READY;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (last_bit && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Shift register, counters and registered outputs. CFG_CE follows the
  // next state so it is a clean flop output that is high exactly while the
  // FSM sits in SHIFT; the async reset drops it without waiting for a clock.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      CFG_CE   <= 1'b0;
      RB_VALID <= 1'b0;
      RB_DATA  <= '0;
      DONE     <= 1'b0;
    end else begin
      RB_VALID <= 1'b0;
      DONE     <= 1'b0;
      CFG_CE   <= (state_nxt == SHIFT);
      if (accept) begin
        shreg   <= WR_DATA;
        bit_cnt <= '0;
      end else if (state == SHIFT) begin
        shreg   <= {shreg[30:0], 1'b0};
        bit_cnt <= bit_cnt + 5'd1;
      end
      if (last_bit) begin
        RB_VALID <= 1'b1;
        RB_DATA  <= {rb_shift[30:0], CFG_CDO};
        if (word_cnt == WORD_LAST) begin
          word_cnt <= '0;
          DONE     <= 1'b1;
        end else begin
          word_cnt <= word_cnt + WCW'(1);
        end
      end
    end
  end

  // Readback shifter: every word fully rewrites it over 32 shifts, so it
  // needs no reset.
  always_ff @(posedge CLK) begin
    if (state == SHIFT) rb_shift <= {rb_shift[30:0], CFG_CDO};
  end

  assign CFG_CDI = shreg[31];
  assign BUSY    = CFG_CE;

endmodule

// File: tb/tb_cfglut_loader.sv
// tb_cfglut_loader
//   Bench for cfglut_loader with a four-LUT chain model attached to the
//   serial configuration pins. Directed steps in one initial block; expected
//   CDI bits and readback words are queued at accept time and compared when
//   the loader produces them.
module tb_cfglut_loader;

  localparam int NL = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        WR_VALID;
  logic        WR_READY;
  logic [31:0] WR_DATA;
  logic        CFG_CE;
  logic        CFG_CDI;
  logic        CFG_CDO;
  logic        RB_VALID;
  logic [31:0] RB_DATA;
  logic        BUSY;
  logic        DONE;

  cfglut_loader #(.NUM_LUTS(NL)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .WR_VALID (WR_VALID),
    .WR_READY (WR_READY),
    .WR_DATA  (WR_DATA),
    .CFG_CE   (CFG_CE),
    .CFG_CDI  (CFG_CDI),
    .CFG_CDO  (CFG_CDO),
    .RB_VALID (RB_VALID),
    .RB_DATA  (RB_DATA),
    .BUSY     (BUSY),
    .DONE     (DONE)
  );

  always #5 CLK = ~CLK;

  // LUT chain model: lut[0] is fed by CDI, lut[NL-1] drives CDO.
  logic [31:0] lut [NL] = '{default: 32'h0};
  always @(posedge CLK) begin
    if (CFG_CE === 1'b1) begin
      lut[0] <= {lut[0][30:0], CFG_CDI};
      for (int i = 1; i < NL; i++) lut[i] <= {lut[i][30:0], lut[i-1][31]};
    end
  end
  assign CFG_CDO = lut[NL-1][31];

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;
  int ce_cycles = 0;
  int n_acc  = 0;
  int n_rb   = 0;
  int n_done = 0;
  int rb_cnt = 0;

  logic [31:0] chain_q [$];   // expected chain contents, last LUT first
  logic [31:0] rb_exp  [$];
  logic        cdi_q   [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: record an accept happening at this edge, then inspect outputs
  // 1 time unit after the edge.
  task automatic tick(output bit acc);
    logic [31:0] w;
    acc = (WR_VALID === 1'b1) && (WR_READY === 1'b1);
    if (acc) begin
      w = WR_DATA;
      rb_exp.push_back(chain_q.pop_front());
      chain_q.push_back(w);
      for (int b = 31; b >= 0; b--) cdi_q.push_back(w[b]);
      n_acc++;
    end
    @(posedge CLK);
    #1;
    cycle++;
    chk("busy_eq_ce", 32'(BUSY), 32'(CFG_CE));
    if (CFG_CE === 1'b1) begin
      ce_cycles++;
      if (cdi_q.size() == 0) chk("cdi_queue_empty", 32'(cdi_q.size() == 0), 32'd0);
      else                   chk("cdi", 32'(CFG_CDI), 32'(cdi_q.pop_front()));
    end
    if (RB_VALID === 1'b1) begin
      rb_cnt++;
      n_rb++;
      if (rb_exp.size() == 0) chk("rb_queue_empty", 32'(rb_exp.size() == 0), 32'd0);
      else                    chk("rb_data", RB_DATA, rb_exp.pop_front());
      chk("done_on_rb", 32'(DONE), 32'((rb_cnt % NL) == 0));
      if (DONE === 1'b1) n_done++;
    end else begin
      chk("done_idle", 32'(DONE), 32'd0);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    bit acc;
    acc = 1'b0;
    WR_DATA  = w;
    WR_VALID = 1'b1;
    for (int i = 0; i < 100 && !acc; i++) tick(acc);
    chk("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic wait_idle();
    bit acc;
    for (int i = 0; i < 200 && CFG_CE === 1'b1; i++) tick(acc);
    chk("idle_timeout", 32'(CFG_CE), 32'd0);
  endtask

  initial begin
    bit acc;
    int ce0, c0, d0, a0, rb0;
    chain_q = '{32'h0, 32'h0, 32'h0, 32'h0};
    RST = 1'b1;
    WR_VALID = 1'b0;
    WR_DATA = 32'h0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ce",     32'(CFG_CE),   32'd0);
    chk("rst_cdi",    32'(CFG_CDI),  32'd0);
    chk("rst_rbv",    32'(RB_VALID), 32'd0);
    chk("rst_rbdata", RB_DATA,       32'h0);
    chk("rst_busy",   32'(BUSY),     32'd0);
    chk("rst_done",   32'(DONE),     32'd0);
    chk("rst_ready",  32'(WR_READY), 32'd0);
    RST = 1'b0;
    #1;
    chk("ready_after_rst", 32'(WR_READY), 32'd1);

    // Chain order: four words back-to-back with WR_VALID held.
    ce0 = ce_cycles; c0 = cycle; d0 = n_done;
    send_word(32'h11111111);
    send_word(32'h22222222);
    send_word(32'h33333333);
    send_word(32'h44444444);
    WR_VALID = 1'b0;
    wait_idle();
    chk("chain_ce_cycles", 32'(ce_cycles - ce0), 32'd128);
    chk("chain_span",      32'(cycle - c0),      32'd129);
    chk("chain_lut3", lut[3], 32'h11111111);
    chk("chain_lut2", lut[2], 32'h22222222);
    chk("chain_lut1", lut[1], 32'h33333333);
    chk("chain_lut0", lut[0], 32'h44444444);
    chk("chain_done", 32'(n_done - d0), 32'd1);

    // Readback: two words, then enough loads to push them out the far end.
    send_word(32'hAAAA5555);
    send_word(32'h0F0F0F0F);
    WR_VALID = 1'b0;
    wait_idle();
    repeat (3) tick(acc);
    send_word(32'h12345678);
    send_word(32'h9ABCDEF0);
    send_word(32'h01234567);
    send_word(32'h89ABCDEF);
    WR_VALID = 1'b0;
    wait_idle();
    repeat (4) tick(acc);
    chk("rb_hold", RB_DATA, 32'h0F0F0F0F);

    // Stall: a second word held valid during the whole shift of the first.
    a0 = n_acc;
    WR_DATA = 32'hCAFEF00D;
    WR_VALID = 1'b1;
    tick(acc);
    chk("stall_first_acc", 32'(acc), 32'd1);
    WR_DATA = 32'h600DD00D;
    for (int k = 1; k <= 31; k++) begin
      chk("stall_ready_low", 32'(WR_READY), 32'd0);
      tick(acc);
      chk("stall_no_acc", 32'(acc), 32'd0);
    end
    chk("stall_ready_last", 32'(WR_READY), 32'd1);
    tick(acc);
    chk("stall_second_acc", 32'(acc), 32'd1);
    WR_VALID = 1'b0;
    wait_idle();
    chk("stall_accepts", 32'(n_acc - a0), 32'd2);
    chk("stall_lut1", lut[1], 32'hCAFEF00D);
    chk("stall_lut0", lut[0], 32'h600DD00D);

    // Single load.
    ce0 = ce_cycles;
    send_word(32'hDEADBEEF);
    WR_VALID = 1'b0;
    wait_idle();
    chk("single_ce_cycles", 32'(ce_cycles - ce0), 32'd32);
    chk("single_lut0",  lut[0], 32'hDEADBEEF);
    chk("single_busy",  32'(BUSY),     32'd0);
    chk("single_ready", 32'(WR_READY), 32'd1);

    // Reset in cycle 17 of a shift.
    send_word(32'h5A5A5A5A);
    WR_VALID = 1'b0;
    repeat (16) tick(acc);
    rb0 = n_rb; d0 = n_done;
    RST = 1'b1;
    #1;
    chk("midrst_ce",    32'(CFG_CE),   32'd0);
    chk("midrst_busy",  32'(BUSY),     32'd0);
    chk("midrst_ready", 32'(WR_READY), 32'd0);
    cdi_q.delete();
    repeat (3) tick(acc);
    RST = 1'b0;
    #1;
    chk("midrst_no_rb",   32'(n_rb - rb0),   32'd0);
    chk("midrst_no_done", 32'(n_done - d0),  32'd0);
    chk("midrst_ready_after", 32'(WR_READY), 32'd1);
    chain_q = '{lut[3], lut[2], lut[1], lut[0]};
    rb_exp.delete();
    rb_cnt = 0;
    d0 = n_done;
    send_word(32'hA1A1A1A1);
    send_word(32'hB2B2B2B2);
    send_word(32'hC3C3C3C3);
    send_word(32'hD4D4D4D4);
    WR_VALID = 1'b0;
    wait_idle();
    chk("fresh_done", 32'(n_done - d0), 32'd1);
    chk("fresh_lut3", lut[3], 32'hA1A1A1A1);
    chk("fresh_lut0", lut[0], 32'hD4D4D4D4);

    // Idle gaps between words.
    d0 = n_done;
    for (int j = 0; j < NL; j++) begin
      send_word(32'h13579BDF ^ (32'h01010101 * j));
      WR_VALID = 1'b0;
      wait_idle();
      repeat (5) begin
        tick(acc);
        chk("gap_ce", 32'(CFG_CE), 32'd0);
      end
    end
    chk("gap_done", 32'(n_done - d0), 32'd1);
    chk("gap_lut0", lut[0], 32'h13579BDF ^ 32'h03030303);

    chk("rb_drained",  32'(rb_exp.size()), 32'd0);
    chk("cdi_drained", 32'(cdi_q.size()),  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
